// File: rtl/forwarding_ctrl.sv
// LC-3b EX-stage operand forwarding and load-use hazard control.
// Optional performance counters are built only when FWD_PERF_CNT_EN is defined.

package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef enum logic [3:0] {
        op_br   = 4'd0,
        op_add  = 4'd1,
        op_ldb  = 4'd2,
        op_stb  = 4'd3,
        op_jsr  = 4'd4,
        op_and  = 4'd5,
        op_ldr  = 4'd6,
        op_str  = 4'd7,
        op_rti  = 4'd8,
        op_not  = 4'd9,
        op_ldi  = 4'd10,
        op_sti  = 4'd11,
        op_jmp  = 4'd12,
        op_shf  = 4'd13,
        op_lea  = 4'd14,
        op_trap = 4'd15
    } lc3b_opcode;
endpackage

module forwarding_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall,
    input  logic             ex_valid,
    input  lc3b_reg          ex_sr1,
    input  lc3b_reg          ex_sr2,
    input  logic             ex_sr1_used,
    input  logic             ex_sr2_used,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  lc3b_opcode       mem_opcode,
    input  lc3b_reg          mem_dest,
    input  logic             mem_done,
    input  logic             wb_valid,
    input  logic             wb_regwrite,
    input  lc3b_reg          wb_dest,
    input  lc3b_word         wb_data,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output lc3b_word         hold_data,
    output logic             stall_front,
    output logic             bubble_mem,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] lu_events
);

    typedef enum logic {ST_RUN, ST_WAIT_LOAD} state_t;

    state_t   state_q, state_d;
    logic     hold_valid_q, hold_valid_d;
    lc3b_reg  hold_dest_q, hold_dest_d;
    lc3b_word hold_data_q, hold_data_d;

    logic [1:0] sel_a, sel_b;
    logic       load_class;
    logic       lu_hazard;
    logic       stall_raw;

    // MEM is the youngest producer, so it outranks WB, which outranks the retire buffer.
    function automatic logic [1:0] src_sel(
        input logic    used,
        input lc3b_reg sr,
        input logic    mem_en,
        input lc3b_reg mdest,
        input logic    wb_en,
        input lc3b_reg wdest,
        input logic    hold_en,
        input lc3b_reg hdest
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (mem_en && (mdest == sr))        sel = 2'b01;
            else if (wb_en && (wdest == sr))    sel = 2'b10;
            else if (hold_en && (hdest == sr))  sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        sel_a = src_sel(ex_sr1_used, ex_sr1,
                        ex_valid & mem_valid & mem_regwrite, mem_dest,
                        wb_valid & wb_regwrite, wb_dest,
                        hold_valid_q, hold_dest_q);
        sel_b = src_sel(ex_sr2_used, ex_sr2,
                        ex_valid & mem_valid & mem_regwrite, mem_dest,
                        wb_valid & wb_regwrite, wb_dest,
                        hold_valid_q, hold_dest_q);
        // TRAP's MEM-stage forward value is the vector fetch, not R7, so it waits like a load.
        load_class = (mem_opcode inside {op_ldb, op_ldi, op_ldr, op_trap});
        lu_hazard  = load_class & ((sel_a == 2'b01) | (sel_b == 2'b01));
    end

    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall_raw = lu_hazard;
                if (lu_hazard && !mem_done && !ext_stall) state_d = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                stall_raw = 1'b1;
                if (mem_done && !ext_stall) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Retire buffer bridges the cycle where WB writes the regfile and EX would read it stale.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_dest_d  = hold_dest_q;
        hold_data_d  = hold_data_q;
        if (!ext_stall && wb_valid && wb_regwrite) begin
            hold_valid_d = 1'b1;
            hold_dest_d  = wb_dest;
            hold_data_d  = wb_data;
        end else if (!ext_stall && !stall_raw) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            hold_valid_q <= 1'b0;
            hold_dest_q  <= '0;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_dest_q  <= hold_dest_d;
            hold_data_q  <= hold_data_d;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    // Saturating counters: stop at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        if (stall_raw && !ext_stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((state_q == ST_RUN) && lu_hazard && !ext_stall && (lu_cnt_q != '1))
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign stall_cycles = reset ? '0 : stall_cnt_q;
    assign lu_events    = reset ? '0 : lu_cnt_q;
`else
    assign stall_cycles = '0;
    assign lu_events    = '0;
`endif

    assign fwd_a_sel   = reset ? 2'b00 : sel_a;
    assign fwd_b_sel   = reset ? 2'b00 : sel_b;
    assign stall_front = reset ? 1'b0  : stall_raw;
    assign bubble_mem  = reset ? 1'b0  : stall_raw;
    assign hold_data   = reset ? '0    : hold_data_q;

endmodule

// File: doc/forwarding_ctrl.md
# forwarding_ctrl

Hazard and forwarding control for the LC-3b pipeline: decides where each EX-stage source operand comes from and stalls the front end when that value is not yet available. It compares the EX instruction's source registers against MEM, WB and a one-entry retire buffer of the last WB write. It drives the operand-mux selects that consume `mem_out` / `wb_out`. It also stalls IF/ID/EX and inserts a bubble into EX/MEM on load-use hazards, holding until the MEM stage completes.

## Interface
Parameters:
- `CNT_W`, 16, width of the performance counters.

Ports (all `lc3b_*` types from `lc3b_types`):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ext_stall`  in  1  global pipeline freeze (I/D-cache miss); nothing advances.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_sr1`, `ex_sr2`  in  3  EX source register numbers.
- `ex_sr1_used`, `ex_sr2_used`  in  1  each; source actually read by the instruction.
- `mem_valid`, `mem_regwrite`  in  1  each; MEM instruction valid / writes the register file.
- `mem_opcode`  in  4  `lc3b_opcode` of the MEM instruction.
- `mem_dest`  in  3  MEM destination register.
- `mem_done`  in  1  MEM stage finishes this cycle (final access of LDI/STI).
- `wb_valid`, `wb_regwrite`  in  1  each; WB instruction valid / writes the register file.
- `wb_dest`  in  3  WB destination register.
- `wb_data`  in  16  value written in WB (`wb_out`).
- `fwd_a_sel`, `fwd_b_sel`  out  2  each; 00 regfile, 01 `mem_out`, 10 `wb_out`, 11 `hold_data`.
- `hold_data`  out  16  retire-buffer value.
- `stall_front`  out  1  freeze PC, IF/ID and ID/EX.
- `bubble_mem`  out  1  EX/MEM loads a NOP instead of the EX instruction.
- `stall_cycles`, `lu_events`  out  `CNT_W` each; performance counters.

## Operation
- Load class: `mem_opcode` ∈ {`op_ldb`, `op_ldi`, `op_ldr`, `op_trap`}. TRAP is included because its MEM-stage forward value is not the R7 value.
- Per source *s* (A=sr1, B=sr2), evaluated in priority order; the first match wins:
  - `used_s & ex_valid & mem_valid & mem_regwrite & mem_dest==sr_s` → 01.
  - `wb_valid & wb_regwrite & wb_dest==sr_s` → 10.
  - `hold_valid & hold_dest==sr_s` → 11.
  - otherwise → 00. An unused source is always 00.
- `lu_hazard` = a source selects 01 while MEM is load class.
- FSM states:
  - RUN: `stall_front = lu_hazard`.
    - `lu_hazard & !mem_done & !ext_stall` → WAIT_LOAD.
    - `lu_hazard & mem_done` → stay RUN; the load reaches WB next cycle and forwards via 10.
  - WAIT_LOAD: `stall_front = 1`; `mem_done & !ext_stall` → RUN.
  - `ext_stall` high: state holds.
- `bubble_mem = stall_front`. While `stall_front` is high, the A/B selects for the MEM load source are don't-care.
- Retire buffer (`hold_valid`, `hold_dest`, `hold_data`) covers the regfile write/read same-cycle gap:
  - `!ext_stall & wb_valid & wb_regwrite` → capture {1, `wb_dest`, `wb_data`}.
  - else if `!ext_stall & !stall_front` → `hold_valid` <= 0.
  - otherwise retain.
- While `reset` is high, all combinational outputs are driven 0.

## Timing
- Selects, `stall_front` and `bubble_mem` are combinational from current inputs and state: zero latency.
- `hold_*` and the FSM are registered; hold data is visible the cycle after the WB write.
- Reset values: state RUN; `hold_valid` 0; `hold_data` 0x0000; `hold_dest` 0; counters 0; all outputs 0.
- Reset mid-stall: WAIT_LOAD → RUN, buffer invalidated, on the next edge.
- Simultaneous MEM and WB match on the same register: MEM wins (younger producer).
- `ext_stall` with a WB write pending: no capture; the buffer retains its contents.
- Counters saturate at all-ones and never wrap.

## Configuration
- `FWD_PERF_CNT_EN` defined:
  - `stall_cycles` increments each cycle with `stall_front & !ext_stall`.
  - `lu_events` increments each cycle in RUN with `lu_hazard & !ext_stall`.
- Not defined: both counters are tied to 0 and no counter flops are built; all other behaviour is identical.

## Test plan
- ADD R1 in MEM, EX reads `sr1`=R1 (`used`) → `fwd_a_sel`=01, `stall_front`=0.
- LDR R2 in MEM, EX reads `sr2`=R2, `mem_done` low for 3 cycles then high:
  - `stall_front`=1 for 4 cycles, FSM in WAIT_LOAD for cycles 2–4.
  - Next cycle `fwd_b_sel`=10.
  - With `FWD_PERF_CNT_EN`, `stall_cycles`=4 and `lu_events`=1.
- WB writes R3=0x1234, next cycle EX reads R3 with no MEM/WB match → `fwd_a_sel`=11, `hold_data`=0x1234. One further advancing cycle → `hold_valid` cleared, `fwd_a_sel`=00.
- MEM writes R4 and WB writes R4, EX reads R4 on both sources → both selects 01.
- WAIT_LOAD, then `reset` pulsed one cycle → all outputs 0, state RUN, counters 0. Also: `ext_stall`=1 with a WB write → no capture, counters frozen.
- STR in MEM (`mem_regwrite`=0), EX reads its base register → both selects 00, no stall.
